// File: rtl/canbus_pkg.sv
// rtl/canbus_pkg.sv - shared types and defaults for the CAN bus Dtack/Berr generator
package canbus_pkg;

   // Bus-cycle states; outputs are decoded from these, never from inputs.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DTACK = 2'd2,
      BERR  = 2'd3
   } bus_state_e;

   localparam int DEF_READ_WAIT  = 4;
   localparam int DEF_WRITE_WAIT = 2;
   localparam int DEF_TIMEOUT    = 255;
   localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/wait_state_counter.sv
// rtl/wait_state_counter.sv - loadable saturating down-counter with zero flag
module wait_state_counter
   import canbus_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Load wins over decrement; decrement stops at zero instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/canbus_dtack_generator.sv
// rtl/canbus_dtack_generator.sv - wait-state Dtack and timeout bus-error generator for the CAN window
module canbus_dtack_generator
   import canbus_pkg::*;
#(
   parameter int READ_WAIT  = DEF_READ_WAIT,
   parameter int WRITE_WAIT = DEF_WRITE_WAIT,
   parameter int TIMEOUT    = DEF_TIMEOUT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic Clock,
   input  logic Reset_L,
   input  logic AS_L,
   input  logic CanBusSelect_H,
   input  logic WE_L,
   input  logic CanBusReady_H,
   input  logic ClearTimeout_H,
   output logic CanBusDtack_L,
   output logic CanBusBerr_L,
   output logic CanBusTimeout_H
);

   // The timeout must outlast both wait counts (so Dtack can ever win) and fit the counter.
   generate
      if ((TIMEOUT <= READ_WAIT) || (TIMEOUT <= WRITE_WAIT) ||
          (TIMEOUT > ((2 ** CNT_W) - 1)) || (READ_WAIT < 0) || (WRITE_WAIT < 0)) begin : g_bad_params
         $error("canbus_dtack_generator: illegal READ_WAIT/WRITE_WAIT/TIMEOUT/CNT_W combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] READ_LD   = CNT_W'(READ_WAIT);
   localparam logic [CNT_W-1:0] WRITE_LD  = CNT_W'(WRITE_WAIT);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   bus_state_e       state_q, state_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic             flag_q, flag_d;
   logic             dtack_l_q, dtack_l_d;
   logic             berr_l_q, berr_l_d;

   logic             wc_load;
   logic [CNT_W-1:0] wc_load_val;
   logic             wc_dec;
   logic [CNT_W-1:0] wc_count;
   logic             wc_zero;
   logic             set_flag;

   // Wait-state counter; the WE_L read/write choice is captured by its load value at the start edge.
   wait_state_counter #(
      .CNT_W (CNT_W)
   ) u_wait_cnt (
      .clk      (Clock),
      .rst_n    (Reset_L),
      .load     (wc_load),
      .load_val (wc_load_val),
      .dec      (wc_dec),
      .count    (wc_count),
      .zero     (wc_zero)
   );

   // Next-state, timeout counter and sticky-flag logic; abort outranks ready, ready outranks timeout.
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      wc_load     = 1'b0;
      wc_load_val = READ_LD;
      wc_dec      = 1'b0;
      set_flag    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!AS_L && CanBusSelect_H) begin
               wc_load     = 1'b1;
               wc_load_val = WE_L ? READ_LD : WRITE_LD;
               tcnt_d      = '0;
               state_d     = COUNT;
            end
         end
         COUNT: begin
            if (AS_L) begin
               state_d = IDLE;
            end else if (wc_zero && CanBusReady_H) begin
               state_d = DTACK;
            end else if (tcnt_q == TIMEOUT_C) begin
               state_d  = BERR;
               set_flag = 1'b1;
            end else begin
               wc_dec = 1'b1;
               tcnt_d = tcnt_q + CNT_W'(1);
            end
         end
         DTACK, BERR: begin
            if (AS_L) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A bus error on the same edge as a clear request keeps the flag set.
      if (set_flag) begin
         flag_d = 1'b1;
      end else if (ClearTimeout_H) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end

      dtack_l_d = (state_d != DTACK);
      berr_l_d  = (state_d != BERR);
   end

   // State, timeout counter, flag and registered active-low outputs.
   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q   <= IDLE;
         tcnt_q    <= '0;
         flag_q    <= 1'b0;
         dtack_l_q <= 1'b1;
         berr_l_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         flag_q    <= flag_d;
         dtack_l_q <= dtack_l_d;
         berr_l_q  <= berr_l_d;
      end
   end

   assign CanBusDtack_L   = dtack_l_q;
   assign CanBusBerr_L    = berr_l_q;
   assign CanBusTimeout_H = flag_q;

endmodule
